lfsr_core: RTL and testbench
============================

LFSR_CORE -- requirements
Module: lfsr

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with the ports named clk and rst (rst asserted = 0).
REQ-002 Parameter WIDTH, default 16: shift register width; only 16 needs to be supported.
REQ-003 Parameter SEED, default 16'hECEB: register value loaded on reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 Port en, input, 1 bit: step enable, sampled on the rising edge of clk.
REQ-007 Port rand_bit, output, 1 bit: the bit shifted out by the most recent step (registered).
REQ-008 Port shift_reg, output, 16 bits: the current LFSR state (registered).

Function
REQ-009 The LFSR SHALL be a Fibonacci, right-shifting 16-bit register.
- Feedback bit: fb = s[0] ^ s[2] ^ s[3] ^ s[5].
- This is the maximal-length primitive polynomial, giving period 65535.
REQ-010 On a rising edge with rst deasserted and en=1, the block SHALL perform one step:
- shift_reg <= {fb, s[15:1]}
- rand_bit <= s[0]
- s is the state before the edge.
REQ-011 On a rising edge with en=0, shift_reg and rand_bit SHALL hold their values.
REQ-012 Latency SHALL be one cycle: outputs reflect a step immediately after the edge that samples en=1.
- Consecutive en=1 cycles SHALL step once per cycle.
REQ-013 Both outputs SHALL be driven directly from flops, with no combinational path from en to any output.
REQ-014 Each step SHALL use exactly the feedback and shift rules of REQ-009/010, with no extra masking.
- The all-zero state is unreachable from SEED, so no lock-up recovery logic is required.
REQ-015 After exactly 65535 steps from SEED, shift_reg SHALL equal SEED again.
- SEED SHALL NOT recur at any earlier step.
REQ-016 Idle gaps of any length between steps SHALL NOT alter the sequence of values produced.

Reset
REQ-017 While rst=0, the block SHALL asynchronously (without waiting for a clock edge) force shift_reg = 16'hECEB and rand_bit = 0.
REQ-018 Reset SHALL override en.
- Reset asserted mid-sequence SHALL restart the sequence from SEED.
- The first step after reset release SHALL produce 16'hF675.
REQ-019 Outputs SHALL remain at their reset values after rst deasserts until the first edge that samples en=1.

Verification
REQ-020 Reset check: assert rst=0 for 4 cycles and hold en=0 -> shift_reg=16'hECEB and rand_bit=0 during and after reset.
REQ-021 First steps: three single-cycle en pulses from reset -> after each pulse, shift_reg/rand_bit equal:
- 16'hF675 / 1
- 16'hFB3A / 1
- 16'h7D9D / 0
REQ-022 Hold: drive en=0 for 0-3 random cycles between pulses -> outputs unchanged during the gaps, and the sequence matches a reference model step for step.
REQ-023 Full period: apply 65535 steps, comparing shift_reg and rand_bit against the model after every step -> final shift_reg=16'hECEB, with no earlier match to SEED.
REQ-024 Mid-run reset: assert rst asynchronously (between clock edges) after about 100 steps -> outputs become 16'hECEB/0 immediately; the next step gives 16'hF675.
REQ-025 Back-to-back: hold en=1 for 5 consecutive cycles -> exactly 5 steps occur, one per edge, matching the model.

Source files
------------

// File: rtl/lfsr_core.sv
// 16-bit Fibonacci LFSR (taps 0,2,3,5) emitting one pseudo-random bit per enabled step.
// Latency: one cycle from the edge sampling en=1 to updated shift_reg/rand_bit.
// Backpressure: none; en=0 simply holds state, so idle gaps never perturb the sequence.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'hECEB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rand_bit,
    output logic [WIDTH-1:0] shift_reg
);

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shift form.
    // The seed is nonzero and the polynomial is primitive, so the all-zero
    // state can never be entered and no lock-up escape is needed.
    logic             fb;
    logic [WIDTH-1:0] next_state;

    // Next state: new feedback bit enters at the MSB, everything moves right.
    always_comb begin
        fb         = shift_reg[0] ^ shift_reg[2] ^ shift_reg[3] ^ shift_reg[5];
        next_state = {fb, shift_reg[WIDTH-1:1]};
    end

    // State and output flops; reset forces the seed asynchronously and wins over en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= SEED;
            rand_bit  <= 1'b0;
        end else if (en) begin
            shift_reg <= next_state;
            rand_bit  <= shift_reg[0];
        end
    end

endmodule

// File: tb/tb_lfsr_core.sv
module tb_lfsr_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        rand_bit;
    logic [15:0] shift_reg;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] SEED_VAL = 16'hECEB;

    // Reference model state: value of the register and the last bit shifted out.
    logic [15:0] m_sr = SEED_VAL;
    logic        m_rb = 1'b0;

    lfsr_core #(.WIDTH(16), .SEED(16'hECEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rand_bit  (rand_bit),
        .shift_reg (shift_reg)
    );

    always #5 clk = ~clk;

    // Model: halve the state and add 2^15 when the tapped bits (0,2,3,5) have odd parity.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        int unsigned v;
        int unsigned taps;
        v    = int'(s);
        taps = ((v >> 0) & 1) + ((v >> 2) & 1) + ((v >> 3) & 1) + ((v >> 5) & 1);
        v    = (v / 2) + ((taps % 2) * 32768);
        return v[15:0];
    endfunction

    task automatic model_step();
        m_rb = m_sr[0];
        m_sr = model_next(m_sr);
    endtask

    task automatic model_reset();
        m_sr = SEED_VAL;
        m_rb = 1'b0;
    endtask

    // One-cycle en pulse; returns at the following negedge with outputs settled.
    task automatic pulse();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        en  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (shift_reg !== 16'hECEB || rand_bit !== 1'b0) begin
                errors++;
                $display("FAIL reset_during cyc=%0d got %h/%b want eceb/0", i, shift_reg, rand_bit);
            end
        end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (shift_reg !== 16'hECEB || rand_bit !== 1'b0) begin
                errors++;
                $display("FAIL reset_after cyc=%0d got %h/%b want eceb/0", i, shift_reg, rand_bit);
            end
        end
    endtask

    task automatic test_first_steps();
        logic [15:0] exp_sr [3];
        logic        exp_rb [3];
        exp_sr[0] = 16'hF675; exp_rb[0] = 1'b1;
        exp_sr[1] = 16'hFB3A; exp_rb[1] = 1'b1;
        exp_sr[2] = 16'h7D9D; exp_rb[2] = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse();
            model_step();
            checks++;
            if (shift_reg !== exp_sr[i] || rand_bit !== exp_rb[i]) begin
                errors++;
                $display("FAIL first_step%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, exp_sr[i], exp_rb[i]);
            end
            checks++;
            if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                errors++;
                $display("FAIL first_step_model%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, m_sr, m_rb);
            end
        end
    endtask

    // Random idle gaps between pulses: state frozen while idle, sequence unchanged.
    task automatic test_hold(input int n_steps);
        int gap;
        for (int i = 0; i < n_steps; i++) begin
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                    errors++;
                    $display("FAIL hold_gap step=%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, m_sr, m_rb);
                end
            end
            pulse();
            model_step();
            checks++;
            if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                errors++;
                $display("FAIL hold_step step=%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, m_sr, m_rb);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) en = 1'b0;
            model_step();
            checks++;
            if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                errors++;
                $display("FAIL b2b step=%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, m_sr, m_rb);
            end
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                errors++;
                $display("FAIL b2b_extra got %h/%b want %h/%b", shift_reg, rand_bit, m_sr, m_rb);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        test_hold(100);
        // Assert reset between edges: outputs must change without a clock.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (shift_reg !== 16'hECEB || rand_bit !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async got %h/%b want eceb/0", shift_reg, rand_bit);
        end
        // en=1 while reset held must not step.
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (shift_reg !== 16'hECEB || rand_bit !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_override got %h/%b want eceb/0", shift_reg, rand_bit);
        end
        en  = 1'b0;
        rst = 1'b1;
        model_reset();
        pulse();
        model_step();
        checks++;
        if (shift_reg !== 16'hF675 || shift_reg !== m_sr || rand_bit !== m_rb) begin
            errors++;
            $display("FAIL mid_reset_restart got %h/%b want f675/%b", shift_reg, rand_bit, m_rb);
        end
    endtask

    task automatic test_full_period();
        int early;
        int bad;
        early = 0;
        bad   = 0;
        do_reset();
        @(negedge clk);
        en = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            @(negedge clk);
            if (i == 65535) en = 1'b0;
            model_step();
            checks++;
            if (shift_reg !== m_sr || rand_bit !== m_rb) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL period_step step=%0d got %h/%b want %h/%b", i, shift_reg, rand_bit, m_sr, m_rb);
            end
            if (i < 65535 && shift_reg === SEED_VAL) early++;
        end
        checks++;
        if (shift_reg !== 16'hECEB) begin
            errors++;
            $display("FAIL period_final got %h want eceb", shift_reg);
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL period_early_seed got %0d want 0", early);
        end
    endtask

    initial begin
        test_reset();
        test_first_steps();
        test_hold(40);
        test_back_to_back();
        test_mid_reset();
        test_full_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
